// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU select codes, memory and immediate encodings.
package rv32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 15;
    localparam int unsigned REG_W  = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [SEL_W-1:0] ALU_ADD  = 15'h000C;
    localparam logic [SEL_W-1:0] ALU_SUB  = 15'h200C;
    localparam logic [SEL_W-1:0] ALU_SLL  = 15'h002C;
    localparam logic [SEL_W-1:0] ALU_SLT  = 15'h004C;
    localparam logic [SEL_W-1:0] ALU_SLTU = 15'h006C;
    localparam logic [SEL_W-1:0] ALU_XOR  = 15'h008C;
    localparam logic [SEL_W-1:0] ALU_SRL  = 15'h00AC;
    localparam logic [SEL_W-1:0] ALU_SRA  = 15'h20AC;
    localparam logic [SEL_W-1:0] ALU_OR   = 15'h00CC;
    localparam logic [SEL_W-1:0] ALU_AND  = 15'h00EC;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_e;

    // One ID/EX entry as handed to the execute stage.
    typedef struct packed {
        logic [SEL_W-1:0]  alu_sel;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic              wb_en;
        mem_e              mem;
        logic [2:0]        br;
        logic              is_br;
        logic              is_jump;
        logic              illegal;
    } id_ex_t;

    // R-type select code built from funct7/funct3.
    function automatic logic [SEL_W-1:0] alu_sel_f(input logic [6:0] funct7, input logic [2:0] funct3);
        return {funct7, funct3, 5'b01100};
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate extraction for the I/S/B/U/J formats.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] inst,
    input  imm_e        imm_type,
    output logic [31:0] imm
);

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Assemble the immediate for the requested format.
    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32_alu_decode.sv
// RV32I decode stage: builds ALU select/operands and writeback controls into a one-entry ID/EX register.
module rv32_alu_decode
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [14:0]     out_alu_sel,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    output logic [1:0]      out_mem,
    output logic [2:0]      out_br,
    output logic            out_is_br,
    output logic            out_is_jump,
    output logic            out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    imm_e        imm_type;
    logic [31:0] imm;
    logic [31:0] shamt;
    logic        illegal;
    id_ex_t      dec;

    logic        valid_d, valid_q;
    id_ex_t      entry_d, entry_q;
    logic        accept;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[11:7];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign shamt  = 32'(in_inst[24:20]);

    // Immediate format implied by the opcode.
    always_comb begin
        imm_type = IMM_I;
        case (opcode)
            OPC_STORE:          imm_type = IMM_S;
            OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
            OPC_BRANCH:         imm_type = IMM_B;
            OPC_JAL:            imm_type = IMM_J;
            default:            imm_type = IMM_I;
        endcase
    end

    rv32_imm_gen u_imm_gen (
        .inst     (in_inst),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // Instruction decode into a candidate ID/EX entry.
    always_comb begin
        dec            = '0;
        illegal        = 1'b0;
        dec.store_data = in_rs2_data;
        dec.rd         = rd;
        case (opcode)
            OPC_OP: begin
                dec.src1    = in_rs1_data;
                dec.src2    = in_rs2_data;
                dec.alu_sel = alu_sel_f(funct7, funct3);
                dec.wb_en   = 1'b1;
                illegal     = !((funct7 == 7'h00) ||
                                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                dec.src1  = in_rs1_data;
                dec.wb_en = 1'b1;
                // Only SRAI keeps funct7; no immediate form of SUB exists.
                dec.alu_sel = alu_sel_f((funct3 == 3'b101) ? funct7 : 7'h00, funct3);
                if (funct3 == 3'b001) begin
                    dec.src2 = shamt;
                    illegal  = (funct7 != 7'h00);
                end else if (funct3 == 3'b101) begin
                    dec.src2 = shamt;
                    illegal  = (funct7 != 7'h00) && (funct7 != 7'h20);
                end else begin
                    dec.src2 = imm;
                end
            end
            OPC_LUI: begin
                dec.src2    = imm;
                dec.alu_sel = ALU_ADD;
                dec.wb_en   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.src1    = in_pc;
                dec.src2    = imm;
                dec.alu_sel = ALU_ADD;
                dec.wb_en   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU computes the link value pc+4.
                dec.src1    = in_pc;
                dec.src2    = 32'd4;
                dec.alu_sel = ALU_ADD;
                dec.wb_en   = 1'b1;
                dec.is_jump = 1'b1;
            end
            OPC_LOAD: begin
                dec.src1    = in_rs1_data;
                dec.src2    = imm;
                dec.alu_sel = ALU_ADD;
                dec.mem     = MEM_LOAD;
                dec.wb_en   = 1'b1;
            end
            OPC_STORE: begin
                dec.src1    = in_rs1_data;
                dec.src2    = imm;
                dec.alu_sel = ALU_ADD;
                dec.mem     = MEM_STORE;
            end
            OPC_BRANCH: begin
                dec.src1  = in_rs1_data;
                dec.src2  = in_rs2_data;
                dec.is_br = 1'b1;
                dec.br    = funct3;
                case (funct3)
                    3'b000, 3'b001: dec.alu_sel = ALU_SUB;
                    3'b100, 3'b101: dec.alu_sel = ALU_SLT;
                    3'b110, 3'b111: dec.alu_sel = ALU_SLTU;
                    default:        illegal     = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        if (rd == 5'd0) begin
            dec.wb_en = 1'b0;
        end

        // Illegal entries still travel down the pipe, with all side effects cleared.
        if (illegal) begin
            dec.illegal = 1'b1;
            dec.alu_sel = '0;
            dec.wb_en   = 1'b0;
            dec.mem     = MEM_NONE;
            dec.br      = 3'b000;
            dec.is_br   = 1'b0;
            dec.is_jump = 1'b0;
            dec.src1    = '0;
            dec.src2    = '0;
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Next state of the ID/EX register: flush, then accept, then consume.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            entry_d = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_alu_sel    = entry_q.alu_sel;
    assign out_src1       = entry_q.src1;
    assign out_src2       = entry_q.src2;
    assign out_store_data = entry_q.store_data;
    assign out_rd         = entry_q.rd;
    assign out_wb_en      = entry_q.wb_en;
    assign out_mem        = entry_q.mem;
    assign out_br         = entry_q.br;
    assign out_is_br      = entry_q.is_br;
    assign out_is_jump    = entry_q.is_jump;
    assign out_illegal    = entry_q.illegal;

endmodule

// File: tb/tb_rv32_alu_decode.sv
// Self-checking bench for rv32_alu_decode: directed cases plus randomized traffic against a reference model.
module tb_rv32_alu_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_alu_sel;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic [1:0]  out_mem;
    logic [2:0]  out_br;
    logic        out_is_br;
    logic        out_is_jump;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    rv32_alu_decode dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_sel    (out_alu_sel),
        .out_src1       (out_src1),
        .out_src2       (out_src2),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_wb_en      (out_wb_en),
        .out_mem        (out_mem),
        .out_br         (out_br),
        .out_is_br      (out_is_br),
        .out_is_jump    (out_is_jump),
        .out_illegal    (out_illegal)
    );

    typedef struct packed {
        logic [14:0] sel;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        wb;
        logic [1:0]  mem;
        logic [2:0]  br;
        logic        isbr;
        logic        isj;
        logic        ill;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Mnemonic -> select code table (alt selects SUB/SRA).
    function automatic logic [14:0] sel_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? 15'h200C : 15'h000C;
            3'd1:    return 15'h002C;
            3'd2:    return 15'h004C;
            3'd3:    return 15'h006C;
            3'd4:    return 15'h008C;
            3'd5:    return alt ? 15'h20AC : 15'h00AC;
            3'd6:    return 15'h00CC;
            default: return 15'h00EC;
        endcase
    endfunction

    // Reference decode from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic ok;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        e.sd = b;
        e.rd = i[11:7];
        ok = 1'b1;
        case (op)
            7'h33: begin
                e.s1 = a; e.s2 = b; e.wb = 1'b1;
                if (f7 == 7'h00) e.sel = sel_of(f3, 1'b0);
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.sel = sel_of(f3, 1'b1);
                else ok = 1'b0;
            end
            7'h13: begin
                e.s1 = a; e.wb = 1'b1;
                e.s2 = 32'($signed(i[31:20]));
                e.sel = sel_of(f3, 1'b0);
                if (f3 == 3'd1) begin
                    e.s2 = {27'd0, i[24:20]};
                    ok = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    e.s2 = {27'd0, i[24:20]};
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                    e.sel = sel_of(3'd5, f7 == 7'h20);
                end
            end
            7'h37: begin e.s1 = 0; e.s2 = i & 32'hFFFFF000; e.sel = 15'h000C; e.wb = 1'b1; end
            7'h17: begin e.s1 = pc; e.s2 = i & 32'hFFFFF000; e.sel = 15'h000C; e.wb = 1'b1; end
            7'h6F, 7'h67: begin e.s1 = pc; e.s2 = 32'd4; e.sel = 15'h000C; e.wb = 1'b1; e.isj = 1'b1; end
            7'h03: begin e.s1 = a; e.s2 = 32'($signed(i[31:20])); e.sel = 15'h000C; e.mem = 2'b01; e.wb = 1'b1; end
            7'h23: begin e.s1 = a; e.s2 = 32'($signed({i[31:25], i[11:7]})); e.sel = 15'h000C; e.mem = 2'b10; end
            7'h63: begin
                e.s1 = a; e.s2 = b; e.isbr = 1'b1; e.br = f3;
                if (f3 == 3'd0 || f3 == 3'd1) e.sel = 15'h200C;
                else if (f3 == 3'd4 || f3 == 3'd5) e.sel = 15'h004C;
                else if (f3 == 3'd6 || f3 == 3'd7) e.sel = 15'h006C;
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (i[11:7] == 5'd0) e.wb = 1'b0;
        if (!ok) begin
            e.ill = 1'b1; e.sel = '0; e.wb = 1'b0; e.mem = 2'b00; e.isbr = 1'b0; e.isj = 1'b0;
        end
        return e;
    endfunction

    // Expected ID/EX contents, advanced by the handshake rules.
    logic m_valid;
    exp_t m_e;
    always @(posedge clk) begin
        if (!rst_n) m_valid <= 1'b0;
        else if (flush) m_valid <= 1'b0;
        else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_e     <= model(in_inst, in_pc, in_rs1_data, in_rs2_data);
        end else if (out_ready) m_valid <= 1'b0;
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_valid", 32'(out_valid), 32'(m_valid));
            chk("m_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            if (m_valid) begin
                chk("m_illegal", 32'(out_illegal), 32'(m_e.ill));
                chk("m_alu_sel", 32'(out_alu_sel), 32'(m_e.sel));
                chk("m_wb_en", 32'(out_wb_en), 32'(m_e.wb));
                chk("m_mem", 32'(out_mem), 32'(m_e.mem));
                chk("m_is_br", 32'(out_is_br), 32'(m_e.isbr));
                chk("m_is_jump", 32'(out_is_jump), 32'(m_e.isj));
                chk("m_store_data", out_store_data, m_e.sd);
                if (!m_e.ill) begin
                    chk("m_src1", out_src1, m_e.s1);
                    chk("m_src2", out_src2, m_e.s2);
                end
                if (m_e.wb) chk("m_rd", 32'(out_rd), 32'(m_e.rd));
                if (m_e.isbr) chk("m_br", 32'(out_br), 32'(m_e.br));
            end
        end
    end

    // Random instruction biased toward the opcodes the decoder knows.
    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [0:8];
        int k;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k <= 8) r[6:0] = ops[k];
        else if (k == 9) r[6:0] = {ops[$urandom_range(0, 8)][6:2], 2'(r[1:0] & 2'b10)};
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0, 1:    r[31:25] = 7'h00;
                2:       r[31:25] = 7'h20;
                default: r[31:25] = 7'($urandom);
            endcase
        end
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = i; in_pc = pc; in_rs1_data = a; in_rs2_data = b;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    exp_t pin;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        in_rs1_data = '0; in_rs2_data = '0; flush = 1'b0; out_ready = 1'b0;

        // Pin the reference model itself.
        pin = model(32'h002081B3, 32'h0, 32'd5, 32'd7);
        chk("pin_add_sel", 32'(pin.sel), 32'h000C);
        pin = model(32'h40435293, 32'h0, 32'h80000000, 32'h0);
        chk("pin_srai_sel", 32'(pin.sel), 32'h20AC);
        chk("pin_srai_src2", pin.s2, 32'd4);
        pin = model(32'hFFC10103, 32'h0, 32'h0, 32'h0);
        chk("pin_lw_negimm", pin.s2, 32'hFFFFFFFC);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_sel", 32'(out_alu_sel), 32'd0);
        chk("rst_src1", out_src1, 32'd0);
        chk("rst_src2", out_src2, 32'd0);
        chk("rst_ctrl", 32'({out_rd, out_wb_en, out_mem, out_br, out_is_br, out_is_jump, out_illegal}), 32'd0);
        model_on = 1'b1;

        send(32'h002081B3, 32'h0, 32'd5, 32'd7);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_sel", 32'(out_alu_sel), 32'h000C);
        chk("add_src1", out_src1, 32'd5);
        chk("add_src2", out_src2, 32'd7);
        chk("add_rd", 32'(out_rd), 32'd3);
        chk("add_wb", 32'(out_wb_en), 32'd1);

        send(32'h40435293, 32'h0, 32'h80000000, 32'h0);
        chk("srai_sel", 32'(out_alu_sel), 32'h20AC);
        chk("srai_src2", out_src2, 32'd4);

        send(32'h20435293, 32'h0, 32'h80000000, 32'h0);
        chk("srai_bad_ill", 32'(out_illegal), 32'd1);
        chk("srai_bad_sel", 32'(out_alu_sel), 32'd0);
        chk("srai_bad_wb", 32'(out_wb_en), 32'd0);
        chk("srai_bad_valid", 32'(out_valid), 32'd1);

        send(32'h12345097, 32'h100, 32'h0, 32'h0);
        chk("auipc_src1", out_src1, 32'h100);
        chk("auipc_src2", out_src2, 32'h12345000);
        chk("auipc_sel", 32'(out_alu_sel), 32'h000C);

        send(32'h0000006F, 32'h200, 32'h0, 32'h0);
        chk("jal_src2", out_src2, 32'd4);
        chk("jal_wb", 32'(out_wb_en), 32'd0);
        chk("jal_jump", 32'(out_is_jump), 32'd1);

        send(32'h0020C063, 32'h0, 32'd1, 32'd2);
        chk("blt_sel", 32'(out_alu_sel), 32'h004C);
        chk("blt_isbr", 32'(out_is_br), 32'd1);
        chk("blt_br", 32'(out_br), 32'd4);
        chk("blt_wb", 32'(out_wb_en), 32'd0);

        send(32'h0020A063, 32'h0, 32'd1, 32'd2);
        chk("br010_ill", 32'(out_illegal), 32'd1);
        chk("br010_isbr", 32'(out_is_br), 32'd0);

        // Stall: entry A held while B waits on the input.
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h002081B3; in_rs1_data = 32'h11;
        tick();
        out_ready = 1'b0; in_rs1_data = 32'h22;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_src1", out_src1, 32'h11);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("unstall_valid", 32'(out_valid), 32'd1);
        chk("unstall_src1", out_src1, 32'h22);

        // Flush with a pending entry and an offered instruction.
        out_ready = 1'b0;
        in_valid = 1'b1; in_rs1_data = 32'h44; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("flush_not_captured", 32'(out_valid), 32'd0);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst_n       = ($urandom_range(0, 299) != 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 19) == 0);
            in_inst     = rand_inst();
            in_pc       = $urandom & 32'hFFFFFFFC;
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
        end
        tick();
        model_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
